// File: rtl/gshare_upd_arb_pkg.sv
// gshare PHT update arbiter: shared widths and entry type.
// Defaults stand in for constants.vh when it is not included first.
`ifndef GSH_PHT_SEL
`define GSH_PHT_SEL 10
`endif
`ifndef GSH_PHT_NUM
`define GSH_PHT_NUM (1 << `GSH_PHT_SEL)
`endif
`ifndef GSH_UPD_DEPTH
`define GSH_UPD_DEPTH 4
`endif
`ifndef GSH_UPD_ENT_W
`define GSH_UPD_ENT_W (`GSH_PHT_SEL + 1)
`endif

package gshare_upd_arb_pkg;

  localparam int PHT_SEL   = `GSH_PHT_SEL;
  localparam int PHT_NUM   = `GSH_PHT_NUM;
  localparam int UPD_DEPTH = `GSH_UPD_DEPTH;
  localparam int ENT_W     = `GSH_UPD_ENT_W;

  typedef struct packed {
    logic               cond;
    logic [PHT_SEL-1:0] went;
  } upd_ent_t;

endpackage

// File: rtl/gshare_upd_arb_if.sv
// Request and update bundle between branch units, arbiter
// and the gshare predictor write port.
interface gshare_upd_arb_if;
  import gshare_upd_arb_pkg::*;

  logic               req0_valid;
  logic               req0_cond;
  logic [PHT_SEL-1:0] req0_went;
  logic               req1_valid;
  logic               req1_cond;
  logic [PHT_SEL-1:0] req1_went;
  logic               req_ready;
  logic               upd_we;
  logic               upd_wcond;
  logic [PHT_SEL-1:0] upd_went;
  logic               busy;

  modport master (
    output req0_valid, req0_cond, req0_went,
    output req1_valid, req1_cond, req1_went,
    input  req_ready,
    input  upd_we, upd_wcond, upd_went, busy
  );

  modport slave (
    input  req0_valid, req0_cond, req0_went,
    input  req1_valid, req1_cond, req1_went,
    output req_ready,
    output upd_we, upd_wcond, upd_went, busy
  );

endinterface

// File: rtl/gsh_upd_fifo.sv
// In-order update buffer: up to two pushes and one pop
// per cycle, head and occupancy exposed, no bypass.
module gsh_upd_fifo
  import gshare_upd_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push0,
  input  upd_ent_t         push0_data,
  input  logic             push1,
  input  upd_ent_t         push1_data,
  input  logic             pop,
  output upd_ent_t         head,
  output logic [CNT_W-1:0] count
);

  upd_ent_t         mem_q [DEPTH];
  upd_ent_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // next storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push0) begin
      mem_d[wr_ptr_d] = push0_data;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    if (push1) begin
      mem_d[wr_ptr_d] = push1_data;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push0)
            + CNT_W'(push1) - CNT_W'(pop);
  end

  // control state, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload storage needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/gshare_upd_arb.sv
// Two-port PHT update arbiter feeding gshare_predictor.
// GSH_UPD_STAT_EN adds issued/stall/dual statistics counters.
module gshare_upd_arb
  import gshare_upd_arb_pkg::*;
#(
  parameter  int DEPTH = UPD_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  gshare_upd_arb_if.slave bus
`ifdef GSH_UPD_STAT_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_dual
`endif
);

  localparam logic [CNT_W-1:0] RDY_MAX =
    CNT_W'(DEPTH - 2);

  logic [CNT_W-1:0] count;
  upd_ent_t         head;
  upd_ent_t         req0_ent, req1_ent;
  upd_ent_t         push0_data, push1_data;
  logic             push0, push1, pop;
  logic             ready, acc0, acc1, empty;
  logic             sel_head, sel_r0, sel_r1;
  logic             upd_we_q, upd_we_d;
  upd_ent_t         out_q, out_d;

  assign req0_ent = {bus.req0_cond, bus.req0_went};
  assign req1_ent = {bus.req1_cond, bus.req1_went};

  assign ready = reset_n & (count <= RDY_MAX);
  assign acc0  = bus.req0_valid & ready;
  assign acc1  = bus.req1_valid & ready;
  assign empty = (count == '0);

  assign sel_head = ~empty;
  assign sel_r0   = empty & acc0;
  assign sel_r1   = empty & ~acc0 & acc1;

  // issue the oldest candidate, queue the rest in age order
  always_comb begin
    pop        = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = req0_ent;
    push1_data = req1_ent;
    upd_we_d   = 1'b0;
    out_d      = out_q;
    unique case (1'b1)
      sel_head: begin
        out_d      = head;
        upd_we_d   = 1'b1;
        pop        = 1'b1;
        push0      = acc0 | acc1;
        push0_data = acc0 ? req0_ent : req1_ent;
        push1      = acc0 & acc1;
      end
      sel_r0: begin
        out_d      = req0_ent;
        upd_we_d   = 1'b1;
        push0      = acc1;
        push0_data = req1_ent;
      end
      sel_r1: begin
        out_d    = req1_ent;
        upd_we_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // registered update port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upd_we_q <= 1'b0;
      out_q    <= '0;
    end else begin
      upd_we_q <= upd_we_d;
      out_q    <= out_d;
    end
  end

  gsh_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign bus.req_ready = ready;
  assign bus.upd_we    = upd_we_q;
  assign bus.upd_wcond = out_q.cond;
  assign bus.upd_went  = out_q.went;
  assign bus.busy      = ~empty | upd_we_q;

`ifdef GSH_UPD_STAT_EN
  logic [31:0] iss_q, iss_d;
  logic [31:0] stl_q, stl_d;
  logic [31:0] dul_q, dul_d;

  // statistics next values, wrapping naturally
  always_comb begin
    iss_d = iss_q + 32'(upd_we_q);
    stl_d = stl_q + 32'((bus.req0_valid
          | bus.req1_valid) & ~ready);
    dul_d = dul_q + 32'(acc0 & acc1);
  end

  // statistics counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iss_q <= '0;
      stl_q <= '0;
      dul_q <= '0;
    end else begin
      iss_q <= iss_d;
      stl_q <= stl_d;
      dul_q <= dul_d;
    end
  end

  assign stat_issued = iss_q;
  assign stat_stall  = stl_q;
  assign stat_dual   = dul_q;
`endif

endmodule

// File: tb/tb_gshare_upd_arb.sv
// Scoreboard bench for gshare_upd_arb: in-order issue,
// ready/backpressure, busy, reset drop, PHT streak.
module tb_gshare_upd_arb;
  import gshare_upd_arb_pkg::*;

  localparam int DEPTH = UPD_DEPTH;

  logic clk = 1'b0;
  logic reset_n;

  gshare_upd_arb_if bus();

`ifdef GSH_UPD_STAT_EN
  logic [31:0] st_iss, st_stl, st_dul;
`endif

  gshare_upd_arb #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef GSH_UPD_STAT_EN
    ,
    .stat_issued (st_iss),
    .stat_stall  (st_stl),
    .stat_dual   (st_dul)
`endif
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  upd_ent_t sb[$];
  bit       mon_en = 1'b0;
  logic [1:0] pht [PHT_NUM];

  bit       p0_v = 1'b0, p1_v = 1'b0;
  upd_ent_t p0, p1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic upd_ent_t mk(input bit c,
                                  input int w);
    upd_ent_t e;
    e.cond = c;
    e.went = PHT_SEL'(w);
    return e;
  endfunction

  // One cycle: drive at negedge, decide acceptance from the
  // number of accepted-but-unissued updates (the queue depth).
  task automatic step(input bit rst);
    bit rdy;
    @(negedge clk);
    reset_n = !rst;
    if (rst) sb.delete();
    bus.req0_valid = p0_v;
    bus.req0_cond  = p0.cond;
    bus.req0_went  = p0.went;
    bus.req1_valid = p1_v;
    bus.req1_cond  = p1.cond;
    bus.req1_went  = p1.went;
    rdy = !rst && (sb.size() <= DEPTH - 2);
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    if (rdy) begin
      if (p0_v) begin sb.push_back(p0); p0_v = 0; end
      if (p1_v) begin sb.push_back(p1); p1_v = 0; end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 &&
         (p0_v || p1_v || sb.size() != 0); i++)
      step(1'b0);
    chk(name, 32'(sb.size()) + 32'(p0_v) + 32'(p1_v), 0);
  endtask

  // Monitor: one update per cycle whenever work is pending.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      bit       exp_we;
      upd_ent_t e;
      exp_we = (sb.size() != 0);
      chk("upd_we", 32'(bus.upd_we), 32'(exp_we));
      if (exp_we && bus.upd_we === 1'b1) begin
        e = sb.pop_front();
        chk("upd_wcond", 32'(bus.upd_wcond), 32'(e.cond));
        chk("upd_went", 32'(bus.upd_went), 32'(e.went));
        if (bus.upd_wcond) begin
          if (pht[bus.upd_went] != 2'd3)
            pht[bus.upd_went] = pht[bus.upd_went] + 2'd1;
        end else begin
          if (pht[bus.upd_went] != 2'd0)
            pht[bus.upd_went] = pht[bus.upd_went] - 2'd1;
        end
      end
      chk("busy", 32'(bus.busy),
          32'(exp_we || sb.size() != 0));
    end
  end

  initial begin
    for (int i = 0; i < PHT_NUM; i++) pht[i] = 2'd0;
    p0 = mk(1'b1, 'h15);
    p1 = mk(1'b0, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // reset with a held request: nothing accepted
    p0_v = 1'b1;
    step(1'b1);
    mon_en = 1'b1;
    step(1'b1);
    p0_v = 1'b0;
    step(1'b0);
    step(1'b0);

    // single request
    p0 = mk(1'b1, 'h15); p0_v = 1'b1;
    step(1'b0);
    drain("single_drain");

    // dual request
    p0 = mk(1'b1, 'h03); p0_v = 1'b1;
    p1 = mk(1'b0, 'h07); p1_v = 1'b1;
    step(1'b0);
    drain("dual_drain");

    // backpressure: four cycles of dual requests
    for (int k = 0; k < 4; k++) begin
      if (!p0_v) begin p0 = mk(k[0], 'h40 + 2*k); p0_v = 1; end
      if (!p1_v) begin p1 = mk(~k[0], 'h41 + 2*k); p1_v = 1; end
      step(1'b0);
    end
    drain("bp_drain");

    // same-index taken streak
    pht['h0A] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      p0 = mk(1'b1, 'h0A); p0_v = 1'b1;
      step(1'b0);
    end
    drain("streak_drain");
    chk("pht_streak", 32'(pht['h0A]), 3);

    // reset mid-operation drops queued entries
    p0 = mk(1'b1, 'h11); p0_v = 1'b1;
    p1 = mk(1'b1, 'h12); p1_v = 1'b1;
    step(1'b0);
    p0 = mk(1'b0, 'h13); p0_v = 1'b1;
    p1 = mk(1'b0, 'h14); p1_v = 1'b1;
    step(1'b0);
    step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (!p0_v && $urandom_range(99) < 60) begin
        p0 = mk(1'($urandom), int'($urandom)); p0_v = 1;
      end
      if (!p1_v && $urandom_range(99) < 55) begin
        p1 = mk(1'($urandom), int'($urandom)); p1_v = 1;
      end
      step($urandom_range(99) < 2);
    end
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
